fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage with a request/ack instruction-memory port and an
//   IF/ID pipeline register. A small FSM tracks whether the stage is fetching,
//   holding a fetched word while decode is stalled, or waiting out a response
//   that belongs to a squashed (redirected) request.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous active-high reset
//   StallD      decode stalled, IF/ID holds
//   FlushD      IF/ID loads a bubble
//   PCSrcE      taken branch/jump resolved in execute
//   PCTargetE   redirect target (low bits passed through untouched)
//   imem_req    instruction memory request (level)
//   imem_addr   request address, stable while imem_req=1
//   imem_ack    one-cycle response strobe
//   imem_rdata  instruction word, valid with imem_ack
//   InstrD      instruction to decode
//   PCD         PC of InstrD
//   PCPlus4D    PCD + 4
//   ValidD      InstrD is a real fetched instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DROP  = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pcf_r;
  logic [31:0] pcf_s;
  logic [31:0] req_addr_r;
  logic [31:0] req_addr_s;
  logic [31:0] buf_r;
  logic [31:0] buf_s;
  logic        req_r;
  logic        deliver_s;
  logic [31:0] dword_s;
  logic [31:0] instr_r;
  logic [31:0] instr_s;
  logic [31:0] pcd_r;
  logic [31:0] pcd_s;
  logic [31:0] pcp4_r;
  logic [31:0] pcp4_s;
  logic        valid_r;
  logic        valid_s;

  assign imem_req  = req_r;
  assign imem_addr = req_addr_r;
  assign InstrD    = instr_r;
  assign PCD       = pcd_r;
  assign PCPlus4D  = pcp4_r;
  assign ValidD    = valid_r;

  // Next-state, next-PC and delivery decision for the fetch FSM.
  always_comb begin
    state_s   = state_r;
    pcf_s     = pcf_r;
    buf_s     = buf_r;
    deliver_s = 1'b0;
    dword_s   = buf_r;
    case (state_r)
      FETCH: begin
        if (PCSrcE) begin
          // A redirect squashes whatever this request returns; if the ack is
          // already here we can simply reissue, otherwise wait it out.
          pcf_s = PCTargetE;
          if (imem_ack) begin
            state_s = FETCH;
          end else begin
            state_s = DROP;
          end
        end else if (imem_ack) begin
          if (StallD) begin
            // Park the word; it is offered to decode once the stall lifts.
            buf_s   = imem_rdata;
            state_s = HOLD;
          end else begin
            deliver_s = 1'b1;
            dword_s   = imem_rdata;
            pcf_s     = req_addr_r + 32'd4;
            state_s   = FETCH;
          end
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_s   = PCTargetE;
          state_s = FETCH;
        end else if (!StallD) begin
          deliver_s = 1'b1;
          dword_s   = buf_r;
          pcf_s     = req_addr_r + 32'd4;
          state_s   = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        if (PCSrcE) begin
          pcf_s = PCTargetE;
        end else begin
          pcf_s = pcf_r;
        end
        if (imem_ack) begin
          state_s = FETCH;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = FETCH;
        pcf_s   = pcf_r;
      end
    endcase

    // A fresh request starts whenever FETCH is (re)entered or the current
    // request completes while staying in FETCH.
    if ((state_s == FETCH) && ((state_r != FETCH) || imem_ack)) begin
      req_addr_s = pcf_s;
    end else begin
      req_addr_s = req_addr_r;
    end
  end

  // IF/ID next contents: flush beats stall, stall beats delivery, and an
  // idle cycle inserts a bubble that keeps the previous PC fields.
  always_comb begin
    instr_s = instr_r;
    pcd_s   = pcd_r;
    pcp4_s  = pcp4_r;
    valid_s = valid_r;
    if (FlushD) begin
      instr_s = NOP_INSTR;
      valid_s = 1'b0;
    end else if (StallD) begin
      instr_s = instr_r;
      valid_s = valid_r;
    end else if (deliver_s) begin
      instr_s = dword_s;
      pcd_s   = req_addr_r;
      pcp4_s  = req_addr_r + 32'd4;
      valid_s = 1'b1;
    end else begin
      instr_s = NOP_INSTR;
      valid_s = 1'b0;
    end
  end

  // FSM, PC, request address, hold buffer and registered request strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= FETCH;
      pcf_r      <= RESET_PC;
      req_addr_r <= RESET_PC;
      buf_r      <= 32'h0000_0000;
      req_r      <= 1'b1;
    end else begin
      state_r    <= state_s;
      pcf_r      <= pcf_s;
      req_addr_r <= req_addr_s;
      buf_r      <= buf_s;
      req_r      <= (state_s != HOLD);
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r <= NOP_INSTR;
      pcd_r   <= 32'h0000_0000;
      pcp4_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      instr_r <= instr_s;
      pcd_r   <= pcd_s;
      pcp4_r  <= pcp4_s;
      valid_r <= valid_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  // Reference model: where the fetcher is, what it is waiting for, what it holds.
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_squash;
  logic        m_held;
  logic [31:0] m_held_word;
  logic [31:0] e_instr;
  logic [31:0] e_pcd;
  logic [31:0] e_pcp4;
  logic        e_valid;

  // Memory responder state.
  logic        mem_busy;
  int          mem_lat;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0000_0000;
    m_addr      = 32'h0000_0000;
    m_squash    = 1'b0;
    m_held      = 1'b0;
    m_held_word = 32'h0000_0000;
    e_instr     = NOP;
    e_pcd       = 32'h0000_0000;
    e_pcp4      = 32'h0000_0000;
    e_valid     = 1'b0;
    mem_busy    = 1'b0;
    mem_lat     = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".InstrD"},   InstrD,             e_instr);
    check({tag, ".PCD"},      PCD,                e_pcd);
    check({tag, ".PCPlus4D"}, PCPlus4D,           e_pcp4);
    check({tag, ".ValidD"},   {31'd0, ValidD},    {31'd0, e_valid});
    check({tag, ".req"},      {31'd0, imem_req},  {31'd0, ~m_held});
    check({tag, ".addr"},     imem_addr,          m_addr);
  endtask

  // Advance the model by one clock given the inputs of that cycle.
  task automatic model_step(input logic ack, input logic [31:0] rdata, input logic stall,
                            input logic flush, input logic pcsrc, input logic [31:0] target);
    logic        got;
    logic [31:0] word;
    logic [31:0] where;
    got   = 1'b0;
    word  = 32'h0000_0000;
    where = 32'h0000_0000;
    if (m_held) begin
      if (pcsrc) begin
        m_held = 1'b0;
        m_pc   = target;
        m_addr = target;
      end else if (!stall) begin
        m_held = 1'b0;
        got    = ~flush;
        word   = m_held_word;
        where  = m_addr;
        m_pc   = m_addr + 32'd4;
        m_addr = m_pc;
      end
    end else if (m_squash) begin
      if (pcsrc) m_pc = target;
      if (ack) begin
        m_squash = 1'b0;
        m_addr   = m_pc;
      end
    end else begin
      if (pcsrc) begin
        m_pc = target;
        if (ack) m_addr = target;
        else     m_squash = 1'b1;
      end else if (ack) begin
        if (stall) begin
          m_held      = 1'b1;
          m_held_word = rdata;
        end else begin
          got    = ~flush;
          word   = rdata;
          where  = m_addr;
          m_pc   = m_addr + 32'd4;
          m_addr = m_pc;
        end
      end
    end
    if (flush) begin
      e_instr = NOP;
      e_valid = 1'b0;
    end else if (stall) begin
      e_instr = e_instr;
    end else if (got) begin
      e_instr = word;
      e_pcd   = where;
      e_pcp4  = where + 32'd4;
      e_valid = 1'b1;
    end else begin
      e_instr = NOP;
      e_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), clock it, then compare.
  task automatic step(input logic ack, input logic [31:0] rdata, input logic stall,
                      input logic flush, input logic pcsrc, input logic [31:0] target,
                      input string tag);
    imem_ack   = ack;
    imem_rdata = rdata;
    StallD     = stall;
    FlushD     = flush;
    PCSrcE     = pcsrc;
    PCTargetE  = target;
    model_step(ack, rdata, stall, flush, pcsrc, target);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_cycle();
    logic        ack;
    logic [31:0] tgt;
    if (!mem_busy && imem_req) begin
      mem_busy = 1'b1;
      mem_lat  = int'($urandom_range(0, 3));
    end
    ack = mem_busy && (mem_lat == 0);
    if (ack) mem_busy = 1'b0;
    else if (mem_busy) mem_lat--;
    if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
    else tgt = $urandom;
    step(ack, ack ? mem_word(imem_addr) : $urandom,
         ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
         ($urandom_range(0, 9) == 0), tgt, "rand");
  endtask

  initial begin
    reset      = 1'b1;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'h0000_0000;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    // Release reset: first request goes to RESET_PC.
    reset = 1'b0;
    check_all("rel");

    // Ack two cycles after release.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "r036a");
    step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 32'h0, "r036b");
    check("r036.InstrD", InstrD, 32'h0050_0093);
    check("r036.PCD", PCD, 32'h0000_0000);
    check("r036.PCP4", PCPlus4D, 32'h0000_0004);
    check("r036.addr", imem_addr, 32'h0000_0004);

    // Ack under a three-cycle stall: word parked, no request, IF/ID frozen.
    step(1'b1, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 32'h0, "r037a");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, "r037b");
    check("r037.req", {31'd0, imem_req}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, "r037c");
    check("r037.hold", InstrD, 32'h0050_0093);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "r037d");
    check("r037.InstrD", InstrD, 32'h1111_2222);
    check("r037.PCD", PCD, 32'h0000_0004);

    // Redirect to 0x100 while the request to 8 is outstanding.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, "r038a");
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, "r038b");
    check("r038.valid", {31'd0, ValidD}, 32'd0);
    check("r038.addr", imem_addr, 32'h0000_0100);

    // Flush on the delivering cycle: bubble, PC still advances.
    step(1'b1, 32'h3333_4444, 1'b0, 1'b1, 1'b0, 32'h0, "r039");
    check("r039.InstrD", InstrD, NOP);
    check("r039.addr", imem_addr, 32'h0000_0104);

    // Redirect to the top of the address space and wrap.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "r040a");
    step(1'b1, 32'h5555_6666, 1'b0, 1'b0, 1'b0, 32'h0, "r040b");
    check("r040.PCD", PCD, 32'hFFFF_FFFC);
    check("r040.PCP4", PCPlus4D, 32'h0000_0000);
    check("r040.addr", imem_addr, 32'h0000_0000);

    // Async reset mid-cycle while holding.
    step(1'b1, 32'h7777_8888, 1'b1, 1'b0, 1'b0, 32'h0, "r041a");
    imem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("r041");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    StallD = 1'b0;
    check_all("r041rel");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
